// File: rtl/xnor_gate_unit.sv
// Bitwise XNOR with a combinational result and a 1-cycle registered copy (result, all-equal, match count).
// No backpressure: every in_valid cycle is captured, back-to-back at one result per cycle.
module xnor_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic             all_equal_q,
  output logic [CNT_W-1:0] match_count_q
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             all_eq;
    logic [CNT_W-1:0] cnt;
  } cap_t;

  cap_t             cap_nxt;
  cap_t             cap_r;
  logic [CNT_W-1:0] match_cnt;

  assign c = ~(a ^ b);

  // Popcount of c; CNT_W is wide enough for WIDTH so the sum cannot wrap.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      match_cnt = match_cnt + CNT_W'(c[i]);
    end
  end

  always_comb begin
    cap_nxt        = '0;
    cap_nxt.res    = c;
    cap_nxt.all_eq = &c;
    cap_nxt.cnt    = match_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cap_r <= cap_nxt;
      end
    end
  end

  assign c_q           = cap_r.res;
  assign all_equal_q   = cap_r.all_eq;
  assign match_count_q = cap_r.cnt;

endmodule

// File: tb/tb_xnor_gate_unit.sv
// Bench for xnor_gate_unit: directed WIDTH=1/8 vectors plus a WIDTH=32 random run against a behavioural model.
module tb_xnor_gate_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       a1, b1, v1;
  logic       c1, cq1, ov1, ae1;
  logic [0:0] mc1;
  xnor_gate_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .c(c1), .c_q(cq1), .out_valid(ov1), .all_equal_q(ae1), .match_count_q(mc1)
  );

  // WIDTH=8 instance
  logic [7:0] a8, b8, c8, cq8;
  logic       v8, ov8, ae8;
  logic [3:0] mc8;
  xnor_gate_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .c(c8), .c_q(cq8), .out_valid(ov8), .all_equal_q(ae8), .match_count_q(mc8)
  );

  // WIDTH=32 instance
  logic [31:0] a32, b32, c32, cq32;
  logic        v32, ov32, ae32;
  logic [5:0]  mc32;
  xnor_gate_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .in_valid(v32),
    .c(c32), .c_q(cq32), .out_valid(ov32), .all_equal_q(ae32), .match_count_q(mc32)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model: bit equality, number of equal positions, whole-word equality.
  function automatic logic [31:0] ref_eq_bits(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (x[i] == y[i]);
    return r;
  endfunction

  function automatic int ref_count(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    for (int i = 0; i < 32; i++) if (x[i] == y[i]) n++;
    return n;
  endfunction

  logic [31:0] m_cq;
  logic        m_ov, m_ae;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cq  <= '0;
      m_ov  <= 1'b0;
      m_ae  <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_ov <= v32;
      if (v32) begin
        m_cq  <= ref_eq_bits(a32, b32);
        m_ae  <= (a32 == b32);
        m_cnt <= ref_count(a32, b32);
      end
    end
  end

  logic run32 = 1'b0;

  always @(negedge clk) begin
    if (run32) begin
      check("w32_c",     64'(c32),  64'(ref_eq_bits(a32, b32)));
      check("w32_c_q",   64'(cq32), 64'(m_cq));
      check("w32_ov",    64'(ov32), 64'(m_ov));
      check("w32_ae",    64'(ae32), 64'(m_ae));
      check("w32_count", 64'(mc32), 64'(m_cnt));
    end
  end

  initial begin
    logic [3:0] tt1;
    tt1 = 4'b1001;  // expected c for {a,b} = 00,01,10,11 at index 0..3
    rst = 1'b0;
    a1 = 0; b1 = 0; v1 = 0;
    a8 = 0; b8 = 0; v8 = 0;
    a32 = 0; b32 = 0; v32 = 0;

    // Pin the model with hand-computed values
    check("model_xnor_opp",  64'(ref_eq_bits(32'hFFFF0000, 32'h0000FFFF)), 64'h0);
    check("model_cnt_same",  64'(ref_count(32'h12345678, 32'h12345678)), 64'd32);
    check("model_cnt_1bit",  64'(ref_count(32'h0, 32'h1)), 64'd31);

    #1 rst = 1'b1;
    #2;
    check("rst_c_q",   64'(cq8), 64'h0);
    check("rst_ov",    64'(ov8), 64'h0);
    check("rst_ae",    64'(ae8), 64'h0);
    check("rst_count", 64'(mc8), 64'h0);
    check("rst_ov32",  64'(ov32), 64'h0);

    // WIDTH=1 truth table, 10 time units per vector
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #1 check($sformatf("w1_tt%0d", i), 64'(c1), 64'(tt1[i]));
      #9;
    end

    @(negedge clk) rst = 1'b0;

    // Equal operands
    a8 = 8'hA5; b8 = 8'hA5; v8 = 1'b1;
    #1 check("w8_eq_c", 64'(c8), 64'hFF);
    @(negedge clk) v8 = 1'b0;
    check("w8_eq_c_q",   64'(cq8), 64'hFF);
    check("w8_eq_ae",    64'(ae8), 64'h1);
    check("w8_eq_count", 64'(mc8), 64'd8);
    check("w8_eq_ov",    64'(ov8), 64'h1);

    // All bits differ
    a8 = 8'hF0; b8 = 8'h0F; v8 = 1'b1;
    #1 check("w8_ne_c", 64'(c8), 64'h00);
    @(negedge clk);
    check("w8_ne_c_q",   64'(cq8), 64'h00);
    check("w8_ne_ae",    64'(ae8), 64'h0);
    check("w8_ne_count", 64'(mc8), 64'd0);

    // One differing bit, then hold with in_valid=0
    a8 = 8'h3C; b8 = 8'h3D; v8 = 1'b1;
    @(negedge clk);
    check("w8_1b_c_q",   64'(cq8), 64'hFE);
    check("w8_1b_count", 64'(mc8), 64'd7);
    check("w8_1b_ae",    64'(ae8), 64'h0);
    a8 = 8'h12; b8 = 8'h34; v8 = 1'b0;
    #1 check("w8_hold_c", 64'(c8), 64'hD9);
    @(negedge clk);
    check("w8_hold_c_q",   64'(cq8), 64'hFE);
    check("w8_hold_count", 64'(mc8), 64'd7);
    check("w8_hold_ov",    64'(ov8), 64'h0);

    // Capture pending, then reset between edges
    a8 = 8'h55; b8 = 8'h55; v8 = 1'b1;
    @(negedge clk);
    check("w8_pre_rst_c_q", 64'(cq8), 64'hFF);
    #2 rst = 1'b1;
    #1;
    check("w8_mrst_c_q",   64'(cq8), 64'h0);
    check("w8_mrst_ov",    64'(ov8), 64'h0);
    check("w8_mrst_ae",    64'(ae8), 64'h0);
    check("w8_mrst_count", 64'(mc8), 64'h0);
    a8 = 8'h0F; b8 = 8'h0E;
    #1 check("w8_mrst_c", 64'(c8), 64'hFE);
    @(negedge clk);
    check("w8_in_rst_c_q", 64'(cq8), 64'h0);
    check("w8_in_rst_ov",  64'(ov8), 64'h0);
    rst = 1'b0;
    a8 = 8'h81; b8 = 8'h80;
    @(negedge clk) v8 = 1'b0;
    check("w8_post_c_q",   64'(cq8), 64'hFE);
    check("w8_post_count", 64'(mc8), 64'd7);
    check("w8_post_ov",    64'(ov8), 64'h1);

    // WIDTH=32 random run against the model
    run32 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      #1;
      a32 = $urandom;
      b32 = ($urandom_range(0, 7) == 0) ? a32 : $urandom;
      v32 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    #1 run32 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xnor_gate_unit.md
# xnor_gate_unit

Bitwise XNOR (equality-compare) unit for the RV32I logic-block library. It produces a purely combinational XNOR of two operand vectors. It also provides a one-cycle registered copy of the result, with valid tracking, an all-bits-equal flag, and a count of matching bit positions. Comparators and ALU-side logic use it when they need either an immediate or a pipelined bit-equality result.

## Interface
Parameters:
- WIDTH, default 1: operand and result width in bits; legal range 1..64.
- CNT_W, default $clog2(WIDTH+1) (minimum 1): width of match_count_q.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  asynchronous, active-high reset of all registered state.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- c  output  WIDTH  combinational result, c = ~(a ^ b).
- c_q  output  WIDTH  registered c, captured when in_valid=1.
- out_valid  output  1  registered in_valid.
- all_equal_q  output  1  registered AND-reduction of c, meaning a == b.
- match_count_q  output  CNT_W  registered popcount of c, meaning the number of equal bit positions.

## Operation
- c is purely combinational from a and b.
  - c does not depend on clk, rst or in_valid.
  - c[i] = 1 exactly when a[i] == b[i].
  - WIDTH=1 truth table (a, b -> c): 00->1, 01->0, 10->0, 11->1.
- Registered path, on each rising clk when rst=0:
  - out_valid <= in_valid.
  - If in_valid=1: c_q <= c; all_equal_q <= &c; match_count_q <= popcount(c).
  - If in_valid=0: c_q, all_equal_q and match_count_q hold their previous values.
- match_count_q range is 0..WIDTH and never overflows, since CNT_W is sized for WIDTH.
- X on a or b propagates to c and to the captured values; no X-masking.

## Timing
- c: zero-cycle combinational latency; it settles within the same delta/propagation window as a and b.
- Registered outputs: exactly 1-cycle latency from the in_valid=1 edge.
- Reset values, asynchronous on rst rising with no clock needed:
  - c_q = 0, out_valid = 0, all_equal_q = 0, match_count_q = 0.
- Reset behaviour:
  - Registered outputs stay at their reset values for as long as rst=1.
  - The first capture happens at the first rising clk with rst=0.
- Reset asserted mid-stream: any pending capture is discarded and outputs clear immediately.
- Reset does not affect c, which keeps tracking a and b during reset.
- Back-to-back in_valid=1 gives one result per cycle; there are no stalls or backpressure.

## Test plan
- WIDTH=1, clk idle, rst=0: apply a,b = 00, 01, 10, 11 with 10 time units each -> c = 1, 0, 0, 1.
- WIDTH=8: a=0xA5, b=0xA5, in_valid=1 for one edge -> c=0xFF immediately; next cycle c_q=0xFF, all_equal_q=1, match_count_q=8, out_valid=1.
- WIDTH=8: a=0xF0, b=0x0F, in_valid=1 -> c=0x00; after the edge c_q=0x00, all_equal_q=0, match_count_q=0.
- WIDTH=8: capture a=0x3C, b=0x3D -> c_q=0xFE, match_count_q=7; then change inputs with in_valid=0 -> c follows the new inputs, registered outputs hold, out_valid=0.
- Assert rst between clock edges after a capture -> all registered outputs go to 0 before the next edge while c still reflects a and b; deassert rst and capture again -> correct result one cycle later.
- WIDTH=32, 1000 random a/b pairs with random in_valid -> c, c_q, all_equal_q and match_count_q match a reference model every cycle.
